// File: rtl/err_dif_unit_pkg.sv
// Shared definitions for the error-diffusion datapath: slot codes, FSM
// state encodings, weight selects and the per-state distribution decode.
package err_dif_unit_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int THRESH_DEF = 128;
    localparam int NUM_SLOTS  = 5;

    // Neighbourhood slot codes (also the load / read addresses)
    localparam logic [2:0] SLOT_CEN   = 3'd0;
    localparam logic [2:0] SLOT_RIGHT = 3'd1;
    localparam logic [2:0] SLOT_LOWL  = 3'd2;
    localparam logic [2:0] SLOT_LOWC  = 3'd3;
    localparam logic [2:0] SLOT_LOWR  = 3'd4;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_QUANT   = 3'd1;
    localparam logic [2:0] ST_DIST_R  = 3'd2;
    localparam logic [2:0] ST_DIST_LL = 3'd3;
    localparam logic [2:0] ST_DIST_LC = 3'd4;
    localparam logic [2:0] ST_DIST_LR = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;

    // Weight selects for the shared weighting unit (7/16, 3/16, 5/16, 1/16)
    localparam logic [1:0] WSEL_7 = 2'd0;
    localparam logic [1:0] WSEL_3 = 2'd1;
    localparam logic [1:0] WSEL_5 = 2'd2;
    localparam logic [1:0] WSEL_1 = 2'd3;

    // One distribution step: which slot is updated and with which weight
    typedef struct packed {
        logic       active;
        logic [2:0] slot;
        logic [1:0] wsel;
    } dist_step_t;

    // True for addresses that name a real slot (5-7 are ignored)
    function automatic logic slot_in_range(input logic [2:0] addr);
        return (addr <= SLOT_LOWR);
    endfunction

    // Map a DIST state onto its target slot and weight
    function automatic dist_step_t dist_step(input logic [2:0] state);
        dist_step_t s;
        s.active = 1'b1;
        case (state)
            ST_DIST_R:  begin s.slot = SLOT_RIGHT; s.wsel = WSEL_7; end
            ST_DIST_LL: begin s.slot = SLOT_LOWL;  s.wsel = WSEL_3; end
            ST_DIST_LC: begin s.slot = SLOT_LOWC;  s.wsel = WSEL_5; end
            ST_DIST_LR: begin s.slot = SLOT_LOWR;  s.wsel = WSEL_1; end
            default:    begin s.slot = SLOT_RIGHT; s.wsel = WSEL_1; s.active = 1'b0; end
        endcase
        return s;
    endfunction

endpackage

// File: rtl/err_dif_weight.sv
// Combinational weighting unit: pix_new = sat(pix + ((w * err) >>> 4)).
// The multiply is shift-add only; the shift floors toward -inf.
import err_dif_unit_pkg::*;

module err_dif_weight #(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic signed [DATA_W:0]   err,
    input  logic        [1:0]        sel,
    input  logic        [DATA_W-1:0] pix,
    output logic        [DATA_W-1:0] pix_new
);

    localparam int PW = DATA_W + 4;  // product width
    localparam int SW = DATA_W + 5;  // sum width

    logic signed [PW-1:0] e_x_s;
    logic signed [PW-1:0] prod_s;
    logic signed [PW-1:0] shr_s;
    logic signed [SW-1:0] sum_s;

    // Weighted error, add to pixel, clamp to the unsigned pixel range
    always_comb begin
        e_x_s = PW'(err);
        case (sel)
            WSEL_7:  prod_s = (e_x_s <<< 3) - e_x_s;
            WSEL_3:  prod_s = (e_x_s <<< 1) + e_x_s;
            WSEL_5:  prod_s = (e_x_s <<< 2) + e_x_s;
            WSEL_1:  prod_s = e_x_s;
            default: prod_s = e_x_s;
        endcase
        shr_s = prod_s >>> 4;
        sum_s = $signed({5'b00000, pix}) + SW'(shr_s);
        if (sum_s[SW-1]) begin
            pix_new = '0;
        end else if (|sum_s[SW-2:DATA_W]) begin
            pix_new = {DATA_W{1'b1}};
        end else begin
            pix_new = sum_s[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/err_dif_unit.sv
// Floyd-Steinberg error-diffusion stage: holds the 5-pixel neighbourhood,
// quantises the centre and spreads the error over the valid neighbours,
// one neighbour per cycle through a single shared weighting unit.
import err_dif_unit_pkg::*;

module err_dif_unit #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int THRESH = THRESH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_en,
    input  logic [2:0]        ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              start,
    input  logic [2:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W:0]   err_out
);

    localparam logic [DATA_W-1:0] PIX_MAX  = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] THRESH_V = DATA_W'(THRESH);

    logic [2:0]              state_r;
    logic [2:0]              state_nxt_s;
    logic [DATA_W-1:0]       buf_r [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]    valid_r;
    logic signed [DATA_W:0]  err_r;
    logic                    busy_r;
    logic                    done_r;

    logic                    ld_hit_s;
    logic                    cen_valid_s;
    logic [DATA_W-1:0]       cen_q_s;
    logic signed [DATA_W:0]  cen_e_s;
    dist_step_t              step_s;
    logic [DATA_W-1:0]       wpix_s;
    logic [DATA_W-1:0]       wnew_s;

    // Loads are only accepted while idle; a same-cycle start sees the new centre
    always_comb begin
        ld_hit_s    = ld_en && (state_r == ST_IDLE) && slot_in_range(ld_addr);
        cen_valid_s = valid_r[SLOT_CEN] || (ld_hit_s && (ld_addr == SLOT_CEN));
        step_s      = dist_step(state_r);
    end

    // Next-state logic of the diffusion sequence
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = cen_valid_s ? ST_QUANT : ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_QUANT:   state_nxt_s = ST_DIST_R;
            ST_DIST_R:  state_nxt_s = ST_DIST_LL;
            ST_DIST_LL: state_nxt_s = ST_DIST_LC;
            ST_DIST_LC: state_nxt_s = ST_DIST_LR;
            ST_DIST_LR: state_nxt_s = ST_DONE;
            ST_DONE:    state_nxt_s = ST_IDLE;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // Threshold quantiser and signed error of the centre pixel
    always_comb begin
        if (buf_r[SLOT_CEN] >= THRESH_V) begin
            cen_q_s = PIX_MAX;
        end else begin
            cen_q_s = '0;
        end
        cen_e_s = $signed({1'b0, buf_r[SLOT_CEN]}) - $signed({1'b0, cen_q_s});
    end

    // Operand mux for the shared weighting unit
    always_comb begin
        case (step_s.slot)
            SLOT_RIGHT: wpix_s = buf_r[SLOT_RIGHT];
            SLOT_LOWL:  wpix_s = buf_r[SLOT_LOWL];
            SLOT_LOWC:  wpix_s = buf_r[SLOT_LOWC];
            SLOT_LOWR:  wpix_s = buf_r[SLOT_LOWR];
            default:    wpix_s = '0;
        endcase
    end

    err_dif_weight #(
        .DATA_W (DATA_W)
    ) u_weight (
        .err     (err_r),
        .sel     (step_s.wsel),
        .pix     (wpix_s),
        .pix_new (wnew_s)
    );

    // Write-back read port, unused addresses read as zero
    always_comb begin
        case (rd_addr)
            SLOT_CEN:   rd_data = buf_r[SLOT_CEN];
            SLOT_RIGHT: rd_data = buf_r[SLOT_RIGHT];
            SLOT_LOWL:  rd_data = buf_r[SLOT_LOWL];
            SLOT_LOWC:  rd_data = buf_r[SLOT_LOWC];
            SLOT_LOWR:  rd_data = buf_r[SLOT_LOWR];
            default:    rd_data = '0;
        endcase
    end

    // Pixel buffer, valid mask and error register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                buf_r[i] <= '0;
            end
            valid_r <= '0;
            err_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        if (ld_hit_s && (ld_addr == 3'(i))) begin
                            buf_r[i]   <= ld_data;
                            valid_r[i] <= 1'b1;
                        end
                    end
                end
                ST_QUANT: begin
                    buf_r[SLOT_CEN] <= cen_q_s;
                    err_r           <= cen_e_s;
                end
                ST_DONE: begin
                    valid_r <= '0;
                end
                default: begin
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        if (step_s.active && (step_s.slot == 3'(i)) && valid_r[i]) begin
                            buf_r[i] <= wnew_s;
                        end
                    end
                end
            endcase
        end
    end

    // State register with registered busy/done derived from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= state_nxt_s inside {ST_QUANT, ST_DIST_R, ST_DIST_LL, ST_DIST_LC, ST_DIST_LR};
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign err_out = err_r;

endmodule

// File: tb/tb_err_dif_unit.sv
// Bench for err_dif_unit: hand-computed vector table, control corner cases
// and randomized runs checked against an integer model of the diffusion rules.
module tb_err_dif_unit;
    import err_dif_unit_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ld_en = 1'b0;
    logic [2:0] ld_addr = 3'd0;
    logic [7:0] ld_data = 8'd0;
    logic       start = 1'b0;
    logic [2:0] rd_addr = 3'd0;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;
    logic [8:0] err_out;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: pixel values, valid flags, last error
    int sh[5];
    bit vld[5];
    int sh_err;

    typedef struct packed {
        logic [4:0][7:0] d;
        logic [4:0]      m;
        logic [4:0][7:0] x;
        int              err;
    } vec_t;

    vec_t tbl[5];

    always #5 clk = ~clk;

    err_dif_unit #(.DATA_W(8), .THRESH(128)) dut (
        .clk     (clk),
        .rst     (rst),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .start   (start),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done),
        .err_out (err_out)
    );

    function automatic vec_t mk(input int c, r, ll, lc, lr, input logic [4:0] m,
                                input int xc, xr, xll, xlc, xlr, e);
        vec_t v;
        v.d[0] = 8'(c);  v.d[1] = 8'(r);  v.d[2] = 8'(ll); v.d[3] = 8'(lc); v.d[4] = 8'(lr);
        v.x[0] = 8'(xc); v.x[1] = 8'(xr); v.x[2] = 8'(xll); v.x[3] = 8'(xlc); v.x[4] = 8'(xlr);
        v.m = m;
        v.err = e;
        return v;
    endfunction

    function automatic int floor16(input int x);
        if (x >= 0) return x / 16;
        return -((-x + 15) / 16);
    endfunction

    function automatic int clamp255(input int x);
        if (x < 0) return 0;
        if (x > 255) return 255;
        return x;
    endfunction

    function automatic void model_load(input int a, input int d);
        if (a < 5) begin
            sh[a]  = d;
            vld[a] = 1'b1;
        end
    endfunction

    // Returns the expected start-to-done latency in cycles
    function automatic int model_start();
        int w[5];
        int q, e, lat;
        w[0] = 0; w[1] = 7; w[2] = 3; w[3] = 5; w[4] = 1;
        lat = 1;
        if (vld[0]) begin
            q = (sh[0] >= 128) ? 255 : 0;
            e = sh[0] - q;
            sh[0] = q;
            sh_err = e;
            for (int k = 1; k < 5; k++)
                if (vld[k]) sh[k] = clamp255(sh[k] + floor16(w[k] * e));
            lat = 6;
        end
        for (int k = 0; k < 5; k++) vld[k] = 1'b0;
        return lat;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_slot(input int a, input int d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 3'(a); ld_data = 8'(d);
        @(negedge clk);
        ld_en = 1'b0;
        model_load(a, d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin sh[k] = 0; vld[k] = 1'b0; end
        sh_err = 0;
    endtask

    task automatic do_start(input string name, input int exp_lat, input bit with_ld,
                            input int a, input int d);
        int lat;
        bit seen;
        lat = 0; seen = 1'b0;
        @(negedge clk);
        start = 1'b1;
        if (with_ld) begin ld_en = 1'b1; ld_addr = 3'(a); ld_data = 8'(d); end
        @(negedge clk);
        start = 1'b0; ld_en = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (done === 1'b1) begin lat = k; seen = 1'b1; break; end
            if (k == 1) chk({name, " busy"}, int'(busy), 1);
            @(negedge clk);
        end
        chk({name, " latency"}, lat, exp_lat);
        if (seen) begin
            chk({name, " busy at done"}, int'(busy), 0);
            @(negedge clk);
            chk({name, " done pulse"}, int'(done), 0);
        end
    endtask

    task automatic check_buf(input string name, input int x0, x1, x2, x3, x4);
        int x[5];
        x[0] = x0; x[1] = x1; x[2] = x2; x[3] = x3; x[4] = x4;
        for (int i = 0; i < 5; i++) begin
            rd_addr = 3'(i);
            #1;
            chk($sformatf("%s slot%0d", name, i), int'(rd_data), x[i]);
        end
    endtask

    initial begin
        int pulses, first, nl, conc, a, d, el;

        tbl[0] = mk(100,  50,  50,  50,  50, 5'b11111,   0,  93, 68, 81, 56,  100);
        tbl[1] = mk(200, 100, 100, 100, 100, 5'b11111, 255,  75, 89, 82, 96,  -55);
        tbl[2] = mk(127, 250,   0,   0,   0, 5'b00011,   0, 255, 89, 82, 96,  127);
        tbl[3] = mk(128,   5,   0,   0,   0, 5'b00011, 255,   0, 89, 82, 96, -127);
        tbl[4] = mk(100,  10,   0,   0,   0, 5'b00011,   0,  53, 89, 82, 96,  100);

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset err_out", int'($signed(err_out)), 0);
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            chk($sformatf("reset rd%0d", i), int'(rd_data), 0);
        end
        @(negedge clk);
        rst = 1'b1;

        // Hand-computed vectors
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 5; i++)
                if (tbl[v].m[i]) load_slot(i, int'(tbl[v].d[i]));
            do_start($sformatf("vec%0d", v), tbl[v].m[0] ? 6 : 1, 1'b0, 0, 0);
            check_buf($sformatf("vec%0d", v), int'(tbl[v].x[0]), int'(tbl[v].x[1]),
                      int'(tbl[v].x[2]), int'(tbl[v].x[3]), int'(tbl[v].x[4]));
            chk($sformatf("vec%0d err", v), int'($signed(err_out)), tbl[v].err);
        end

        // Start with nothing loaded: immediate done, nothing changes
        do_start("noload", 1, 1'b0, 0, 0);
        check_buf("noload", 0, 53, 89, 82, 96);
        chk("noload err", int'($signed(err_out)), 100);

        // Start and load while busy are ignored
        for (int i = 0; i < 5; i++) load_slot(i, int'(tbl[0].d[i]));
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        start = 1'b1; ld_en = 1'b1; ld_addr = SLOT_RIGHT; ld_data = 8'hAA;
        @(negedge clk);
        start = 1'b0; ld_en = 1'b0;
        pulses = 0; first = 0;
        for (int k = 3; k <= 16; k++) begin
            if (done === 1'b1) begin
                pulses++;
                if (first == 0) first = k;
            end
            @(negedge clk);
        end
        chk("busy-ignore pulses", pulses, 1);
        chk("busy-ignore latency", first, 6);
        check_buf("busy-ignore", 0, 93, 68, 81, 56);

        // Reset in the middle of DIST_LC, then a normal run
        for (int i = 0; i < 5; i++) load_slot(i, int'(tbl[0].d[i]));
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midrst busy", int'(busy), 0);
        chk("midrst done", int'(done), 0);
        chk("midrst err", int'($signed(err_out)), 0);
        check_buf("midrst", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) load_slot(i, int'(tbl[1].d[i]));
        do_start("postrst", 6, 1'b0, 0, 0);
        check_buf("postrst", 255, 75, 89, 82, 96);
        chk("postrst err", int'($signed(err_out)), -55);

        // Randomized runs against the reference model
        do_reset();
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) != 0) load_slot(0, int'($urandom_range(0, 255)));
            nl = int'($urandom_range(0, 5));
            for (int j = 0; j < nl; j++)
                load_slot(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
            conc = int'($urandom_range(0, 1));
            a = int'($urandom_range(0, 4));
            d = int'($urandom_range(0, 255));
            if (conc != 0) model_load(a, d);
            el = model_start();
            do_start($sformatf("rnd%0d", it), el, conc != 0, a, d);
            check_buf($sformatf("rnd%0d", it), sh[0], sh[1], sh[2], sh[3], sh[4]);
            chk($sformatf("rnd%0d err", it), int'($signed(err_out)), sh_err);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
